// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: load/store width encodings, MEM-stage FSM states
// and helpers that shape store data onto the 32-bit data bus.
package pipeline_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_e;

  // One in-flight data-memory access, as presented on the bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [2:0]  f3;
  } mem_req_t;

  // size is funct3[1:0]: 00 byte, 01 half, otherwise word.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes so the byte enables pick the target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'b00:   store_lanes = {4{sd[7:0]}};
      2'b01:   store_lanes = {2{sd[15:0]}};
      default: store_lanes = sd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load width.
module load_align
  import pipeline_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data memory over a req/ready handshake, stalls the
// pipeline while an access is outstanding and registers the MEM/WB entry.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [31:0]     alu_result,
  input  logic [31:0]     store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [RD_W-1:0] rd,
  input  logic            reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [31:0]     dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_ready,
  input  logic [31:0]     dmem_rdata,
  output logic            stall,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic            wb_misalign,
  output logic            wb_bus_err
);

  localparam int              CNT_W       = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  mem_state_e       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  mem_req_t         lat_req, cur_req;
  logic [RD_W-1:0]  lat_rd, cur_rd;
  logic             lat_rw, cur_rw;
  logic             latch_en;

  logic             mem_op, f3_ok, align_ok, illegal;
  logic             req_live, done, timeout_hit;
  logic [31:0]      load_data;

  logic             wb_valid_next, wb_reg_write_next, wb_misalign_next, wb_bus_err_next;
  logic [31:0]      wb_data_next;
  logic [RD_W-1:0]  wb_rd_next;

  // Decode legality of the instruction sitting in EX/MEM.
  always_comb begin
    mem_op = ex_valid & (mem_read | mem_write);
    case (funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~mem_write;
      default:          f3_ok = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   align_ok = ~alu_result[0];
      2'b10:   align_ok = (alu_result[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    illegal = mem_op & ((mem_read & mem_write) | ~f3_ok | ~align_ok);
  end

  // While waiting the bus is driven from the latched copy so upstream can change freely.
  always_comb begin
    if (state == MEM_WAIT) begin
      cur_req = lat_req;
      cur_rd  = lat_rd;
      cur_rw  = lat_rw;
    end else begin
      cur_req.addr  = alu_result;
      cur_req.wdata = store_lanes(funct3[1:0], store_data);
      cur_req.be    = store_be(funct3[1:0], alu_result[1:0]);
      cur_req.we    = mem_write;
      cur_req.f3    = funct3;
      cur_rd        = rd;
      cur_rw        = reg_write;
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (cur_req.addr[1:0]),
    .funct3 (cur_req.f3),
    .data   (load_data)
  );

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_next        = state;
    wait_cnt_next     = wait_cnt;
    req_live          = 1'b0;
    latch_en          = 1'b0;
    timeout_hit       = (state == MEM_WAIT) && (wait_cnt == TIMEOUT_CNT);

    case (state)
      MEM_IDLE: begin
        if (mem_op && !illegal) begin
          req_live = 1'b1;
          if (!dmem_ready) begin
            state_next    = MEM_WAIT;
            wait_cnt_next = '0;
            latch_en      = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (timeout_hit) begin
          state_next = MEM_IDLE;
        end else begin
          req_live = 1'b1;
          if (dmem_ready) state_next = MEM_IDLE;
          else            wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      default: state_next = MEM_IDLE;
    endcase

    done = req_live & dmem_ready;

    wb_valid_next     = 1'b0;
    wb_data_next      = '0;
    wb_rd_next        = '0;
    wb_reg_write_next = 1'b0;
    wb_misalign_next  = 1'b0;
    wb_bus_err_next   = 1'b0;

    if (done) begin
      wb_valid_next     = 1'b1;
      wb_data_next      = cur_req.we ? 32'h0 : load_data;
      wb_rd_next        = cur_rd;
      wb_reg_write_next = ~cur_req.we & cur_rw;
    end else if (timeout_hit) begin
      wb_valid_next   = 1'b1;
      wb_bus_err_next = 1'b1;
    end else if (state == MEM_IDLE && illegal) begin
      wb_valid_next    = 1'b1;
      wb_rd_next       = rd;
      wb_misalign_next = 1'b1;
    end else if (state == MEM_IDLE && ex_valid && !mem_op) begin
      wb_valid_next     = 1'b1;
      wb_data_next      = alu_result;
      wb_rd_next        = rd;
      wb_reg_write_next = reg_write;
    end
  end

  // Reset gates the bus and stall combinationally so an abort takes effect at once.
  assign dmem_req   = ~rst & req_live;
  assign stall      = ~rst & req_live & ~dmem_ready;
  assign dmem_we    = dmem_req & cur_req.we;
  assign dmem_addr  = {cur_req.addr[31:2], 2'b00};
  assign dmem_be    = cur_req.be;
  assign dmem_wdata = cur_req.wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= MEM_IDLE;
      wait_cnt     <= '0;
      // NOTE: the latched request is reset only to keep it deterministic; it is
      // never observed outside WAIT, which always follows a fresh latch.
      lat_req      <= '0;
      lat_rd       <= '0;
      lat_rw       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_misalign  <= 1'b0;
      wb_bus_err   <= 1'b0;
    end else begin
      state        <= state_next;
      wait_cnt     <= wait_cnt_next;
      if (latch_en) begin
        lat_req <= cur_req;
        lat_rd  <= cur_rd;
        lat_rw  <= cur_rw;
      end
      wb_valid     <= wb_valid_next;
      wb_data      <= wb_data_next;
      wb_rd        <= wb_rd_next;
      wb_reg_write <= wb_reg_write_next;
      wb_misalign  <= wb_misalign_next;
      wb_bus_err   <= wb_bus_err_next;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed literal cases followed by randomized
// traffic, all compared against a transaction-level model of the stage.
module tb_mem_access_stage;
  localparam int TIMEOUT = 4;
  localparam int RD_W    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, mem_read, mem_write, reg_write;
  logic [31:0]     alu_result, store_data;
  logic [2:0]      funct3;
  logic [RD_W-1:0] rd;
  logic            dmem_req, dmem_we, dmem_ready, stall;
  logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;
  logic            wb_valid, wb_reg_write, wb_misalign, wb_bus_err;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .rd(rd), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit legal_op(input logic mr, input logic mw, input logic [2:0] f3,
                                  input logic [31:0] a);
    if (mr && mw) return 1'b0;
    if (mw && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b0;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdat >> (8 * a[1:0]));
    h = 16'(rdat >> (16 * a[1]));
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return rdat;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'b000) return 4'(1 << off);
    if (f3 == 3'b001) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'b000) return {4{sd[7:0]}};
    if (f3 == 3'b001) return {2{sd[15:0]}};
    return sd;
  endfunction

  bit              m_pend = 0;
  int              m_wait = 0;
  logic [31:0]     m_addr, m_sd;
  logic            m_we, m_rw;
  logic [2:0]      m_f3;
  logic [RD_W-1:0] m_rd;

  logic            e_valid = 0, e_rw = 0, e_mis = 0, e_err = 0;
  logic [31:0]     e_data = 0;
  logic [RD_W-1:0] e_rd = 0;
  bit              e_data_chk = 0, e_rd_chk = 0;

  task automatic set_bubble();
    e_valid = 0; e_rw = 0; e_mis = 0; e_err = 0; e_data_chk = 0; e_rd_chk = 0;
  endtask

  task automatic set_complete(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [RD_W-1:0] r, input logic rw);
    e_valid = 1; e_mis = 0; e_err = 0;
    e_rd = r; e_rd_chk = 1;
    e_rw = we ? 1'b0 : rw;
    e_data_chk = !we;
    e_data = ext_load(f3, a, dmem_rdata);
  endtask

  // One compare process: checks the current cycle, then predicts the next edge.
  initial begin
    bit              x_req;
    logic [31:0]     x_addr, x_sd;
    logic            x_we;
    logic [2:0]      x_f3;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_reg_write", wb_reg_write, 0);
        check("rst_wb_misalign", wb_misalign, 0);
        check("rst_wb_bus_err", wb_bus_err, 0);
        m_pend = 0;
        set_bubble();
      end else begin
        if (m_pend) begin
          x_req = (m_wait < TIMEOUT);
          x_addr = m_addr; x_sd = m_sd; x_we = m_we; x_f3 = m_f3;
        end else begin
          x_req = ex_valid && (mem_read || mem_write) &&
                  legal_op(mem_read, mem_write, funct3, alu_result);
          x_addr = alu_result; x_sd = store_data; x_we = mem_write; x_f3 = funct3;
        end
        check("m_req", dmem_req, x_req);
        check("m_stall", stall, x_req && !dmem_ready);
        if (x_req) begin
          check("m_addr", dmem_addr, x_addr & 32'hFFFF_FFFC);
          check("m_we", dmem_we, x_we);
          if (x_we) begin
            check("m_be", dmem_be, exp_be(x_f3, x_addr[1:0]));
            check("m_wdata", dmem_wdata, exp_wdata(x_f3, x_sd));
          end
        end
        check("m_wb_valid", wb_valid, e_valid);
        check("m_wb_reg_write", wb_reg_write, e_rw);
        check("m_wb_misalign", wb_misalign, e_mis);
        check("m_wb_bus_err", wb_bus_err, e_err);
        if (e_data_chk) check("m_wb_data", wb_data, e_data);
        if (e_rd_chk)   check("m_wb_rd", wb_rd, e_rd);

        if (!m_pend) begin
          if (ex_valid && (mem_read || mem_write)) begin
            if (!legal_op(mem_read, mem_write, funct3, alu_result)) begin
              set_bubble();
              e_valid = 1; e_mis = 1;
            end else if (dmem_ready) begin
              set_complete(mem_write, funct3, alu_result, rd, reg_write);
            end else begin
              m_pend = 1; m_wait = 0;
              m_addr = alu_result; m_sd = store_data; m_we = mem_write;
              m_f3 = funct3; m_rd = rd; m_rw = reg_write;
              set_bubble();
            end
          end else if (ex_valid) begin
            e_valid = 1; e_rw = reg_write; e_mis = 0; e_err = 0;
            e_data = alu_result; e_data_chk = 1; e_rd = rd; e_rd_chk = 1;
          end else begin
            set_bubble();
          end
        end else begin
          if (m_wait == TIMEOUT) begin
            set_bubble();
            e_valid = 1; e_err = 1;
            m_pend = 0;
          end else if (dmem_ready) begin
            set_complete(m_we, m_f3, m_addr, m_rd, m_rw);
            m_pend = 0;
          end else begin
            m_wait++;
            set_bubble();
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic ev, input logic [31:0] alu, input logic [31:0] sd,
                       input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [RD_W-1:0] r, input logic rw_i, input logic rdy,
                       input logic [31:0] rdat);
    ex_valid = ev; alu_result = alu; store_data = sd; mem_read = mr; mem_write = mw;
    funct3 = f3; rd = r; reg_write = rw_i; dmem_ready = rdy; dmem_rdata = rdat;
  endtask

  task automatic idle(input logic rdy = 1'b0);
    drive(1'b0, $urandom, $urandom, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1, rdy, $urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lb(input logic [2:0] f3, input logic [31:0] exp_val, input string tag);
    drive(1, 32'h102, 0, 1, 0, f3, 5'd9, 1, 0, 0);
    #2 check({tag, "_stall0"}, stall, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'hDEAD_0000, 32'h1111_1111, 0, 1, 3'b010, 5'd1, 0, 0, 0);
      #2 check({tag, "_stall_wait"}, stall, 1);
      check({tag, "_addr_stable"}, dmem_addr, 32'h100);
      check({tag, "_we_stable"}, dmem_we, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1280_FF00);
    #2 check({tag, "_stall_rel"}, stall, 0);
    tick();
    idle();
    #2 check({tag, "_wb_valid"}, wb_valid, 1);
    check({tag, "_wb_data"}, wb_data, exp_val);
    check({tag, "_wb_rd"}, wb_rd, 9);
    check({tag, "_wb_rw"}, wb_reg_write, 1);
    tick();
  endtask

  task automatic bad_op(input logic [31:0] alu, input logic mr, input logic mw,
                        input logic [2:0] f3, input string tag);
    drive(1, alu, 32'h5555_AAAA, mr, mw, f3, 5'd4, 1, 1, 0);
    #2 check({tag, "_req"}, dmem_req, 0);
    check({tag, "_stall"}, stall, 0);
    tick();
    idle();
    #2 check({tag, "_wb_valid"}, wb_valid, 1);
    check({tag, "_wb_misalign"}, wb_misalign, 1);
    check({tag, "_wb_rw"}, wb_reg_write, 0);
    check({tag, "_wb_bus_err"}, wb_bus_err, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 32'h0, 0, 1, 0, 3'b010, 5'd2, 1, 1, 32'h1234_5678);
    #2 check("reset_req", dmem_req, 0);
    check("reset_stall", stall, 0);
    repeat (3) tick();
    idle();
    rst = 1'b0;
    tick();

    // Non-memory pass-through.
    drive(1, 32'h0000_1234, 0, 0, 0, 3'b010, 5'd7, 1, 0, 0);
    #2 check("alu_req", dmem_req, 0);
    tick();
    idle();
    #2 check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_data", wb_data, 32'h1234);
    check("alu_wb_rd", wb_rd, 7);
    check("alu_wb_rw", wb_reg_write, 1);
    tick();

    // SB with same-cycle ready.
    drive(1, 32'h103, 32'hAABB_CC5A, 0, 1, 3'b000, 5'd3, 1, 1, 0);
    #2 check("sb_req", dmem_req, 1);
    check("sb_addr", dmem_addr, 32'h100);
    check("sb_be", dmem_be, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    check("sb_we", dmem_we, 1);
    check("sb_stall", stall, 0);
    tick();
    idle();
    #2 check("sb_wb_valid", wb_valid, 1);
    check("sb_wb_rw", wb_reg_write, 0);
    tick();

    do_lb(3'b000, 32'hFFFF_FF80, "lb");
    do_lb(3'b100, 32'h0000_0080, "lbu");

    bad_op(32'h206, 1, 0, 3'b010, "lw_mis");
    bad_op(32'h201, 0, 1, 3'b001, "sh_mis");
    bad_op(32'h200, 1, 1, 3'b010, "rdwr");

    // Timeout: issue cycle plus TIMEOUT waiting cycles hold the request, then abort.
    drive(1, 32'h300, 0, 1, 0, 3'b001, 5'd6, 1, 0, 0);
    #2 check("to_req_issue", dmem_req, 1);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      idle(1'b0);
      #2 check("to_req_held", dmem_req, 1);
      check("to_addr_held", dmem_addr, 32'h300);
      check("to_stall_held", stall, 1);
      tick();
    end
    idle(1'b1);
    #2 check("to_req_drop", dmem_req, 0);
    check("to_stall_rel", stall, 0);
    tick();
    idle();
    #2 check("to_wb_bus_err", wb_bus_err, 1);
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_rw", wb_reg_write, 0);
    check("to_wb_misalign", wb_misalign, 0);
    tick();
    #2 check("to_err_pulse", wb_bus_err, 0);
    tick();

    // Asynchronous reset while waiting.
    drive(1, 32'h400, 0, 1, 0, 3'b010, 5'd8, 1, 0, 0);
    tick();
    idle(1'b0);
    #2 check("rw_req_wait", dmem_req, 1);
    rst = 1'b1;
    #1 check("rw_req_drop", dmem_req, 0);
    check("rw_stall_drop", stall, 0);
    check("rw_wb_valid", wb_valid, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 32'h404, 0, 1, 0, 3'b010, 5'd12, 1, 1, 32'hCAFE_F00D);
    #2 check("post_rst_req", dmem_req, 1);
    check("post_rst_addr", dmem_addr, 32'h404);
    tick();
    idle();
    #2 check("post_rst_wb_valid", wb_valid, 1);
    check("post_rst_wb_data", wb_data, 32'hCAFE_F00D);
    check("post_rst_wb_rd", wb_rd, 12);
    tick();

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic        ev, mr, mw;
      logic [2:0]  f3;
      logic [31:0] a;
      int          kind;
      ev   = ($urandom_range(9) < 8);
      kind = $urandom_range(2);
      mr   = (kind == 1);
      mw   = (kind == 2);
      if ($urandom_range(15) == 0) begin mr = 1; mw = 1; end
      if ($urandom_range(9) < 8) begin
        case ($urandom_range(4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom_range(1) == 0) a[1:0] = 2'b00;
      drive(ev, a, $urandom, mr, mw, f3, 5'($urandom), 1'($urandom),
            ($urandom_range(9) < 4), $urandom);
      tick();
    end
    idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the execute ALU.
- Takes the ALU result as the effective address (or as pass-through data for non-memory instructions).
- Drives a single-port data memory through a req/ready handshake; builds byte enables and store data; extracts and sign/zero-extends load data.
- Registers the result as the MEM/WB pipeline register. Stalls the pipeline while memory is outstanding.

Parameters:
- TIMEOUT, default 255: max cycles in WAIT before abort with bus error (1..65535).
- RD_W, default 5: destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX/MEM entry holds a live instruction.
- alu_result  in  32  ALU output: address for load/store, data otherwise.
- store_data  in  32  rs2 value for stores.
- mem_read  in  1  load.
- mem_write  in  1  store.
- funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd  in  RD_W  destination register.
- reg_write  in  1  instruction writes rd.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word address; alu_result with [1:0] forced to 00.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  access complete; dmem_rdata valid this cycle for reads.
- dmem_rdata  in  32  read word.
- stall  out  1  hold EX/MEM and upstream stages this cycle.
- wb_valid  out  1  registered: MEM/WB entry live.
- wb_data  out  32  registered writeback data.
- wb_rd  out  RD_W  registered.
- wb_reg_write  out  1  registered; forced 0 on any error.
- wb_misalign  out  1  registered one-cycle pulse: misaligned or illegal access.
- wb_bus_err  out  1  registered one-cycle pulse: timeout abort.

Behaviour:
- Reset: state IDLE, timeout counter 0, all wb_* outputs 0. dmem_req=0 and stall=0 while rst is high, regardless of inputs.
- FSM has two states: IDLE and WAIT.
- A memory op is ex_valid & (mem_read | mem_write).
- Illegal/misaligned ops (no request issued):
  - mem_read & mem_write both set.
  - funct3 not in the list above, or a store with funct3 100/101.
  - H with addr[0]=1.
  - W with addr[1:0]≠00.
- IDLE, non-memory instruction with ex_valid: next edge wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write. Latency 1, stall=0.
- IDLE, ex_valid=0: next edge wb_valid=0, wb_reg_write=0.
- IDLE, illegal op: next edge wb_valid=1, wb_reg_write=0, wb_misalign=1. No dmem_req, stall=0.
- IDLE, legal memory op:
  - dmem_req=1 combinationally from the inputs in the same cycle.
  - If dmem_ready is also 1: complete at the next edge, stall=0.
  - Otherwise: stall=1, latch addr/be/wdata/we/funct3/rd/reg_write, go to WAIT.
- WAIT:
  - dmem_req=1 with the latched values, stable until the handshake; inputs are ignored. stall = ~dmem_ready.
  - On dmem_ready: complete at the next edge, return to IDLE.
  - Counter increments each WAIT cycle without ready. When it reaches TIMEOUT: drop dmem_req, return to IDLE, wb_valid=1, wb_reg_write=0, wb_bus_err=1, stall=0 that cycle.
- Store encoding, with off = addr[1:0]:
  - B: be = 0001<<off, wdata = {4{sd[7:0]}}.
  - H: be = 0011<<off, wdata = {2{sd[15:0]}}.
  - W: be = 1111, wdata = sd.
- Store completion: wb_reg_write=0.
- Load extraction:
  - B/BU: byte = rdata[8*off+:8].
  - H/HU: half = rdata[16*off[1]+:16].
  - Sign-extend for B/H; zero-extend for BU/HU.
- Load completion: wb_data = extracted value, wb_reg_write = latched reg_write.
- dmem_ready while dmem_req=0 is ignored.
- wb_misalign and wb_bus_err are never both set.
- Async rst mid-WAIT: abort immediately, no writeback. The memory side must tolerate the dropped request.

Decomposition:
- Shared package pipeline_pkg holds:
  - funct3 load/store width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - MEM FSM state typedef.
- One natural sub-module, load_align: combinational extract and sign/zero-extend from (rdata, off, funct3).

Test Plan:
- Non-mem op, alu_result=0x0000_1234, rd=7, reg_write=1 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=7; dmem_req never asserted.
- SB addr=0x103, sd=0xAABBCC5A, ready same cycle → dmem_addr=0x100, be=1000, wdata=0x5A5A5A5A, we=1, stall=0, wb_reg_write=0.
- LB addr=0x102, rdata=0x1280_FF00, ready after 3 cycles → stall high 3 cycles, req fields stable; wb_data=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- LW addr=0x206 → no req; wb_misalign=1, wb_reg_write=0. Same result for SH addr=0x201 and for mem_read=mem_write=1.
- LH addr=0x300 with ready held low and TIMEOUT=4 → req held 4 cycles, then dropped; wb_bus_err=1, stall released.
- rst pulsed during WAIT → dmem_req and stall drop asynchronously; wb_* outputs 0; next legal op completes normally.
